// File: rtl/unpacked_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter with unpacked per-lane ports.
package unpacked_arb_pkg;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} arb_state_t;

  // Index that follows i in a ring of n lanes.
  function automatic int next_idx(input int i, input int n);
    return (i == n - 1) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/unpacked_rr_arbiter_rr_pick.sv
// Rotating-priority picker: first valid lane at or after ptr, wrapping N-1 -> 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          valid [N],
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] winner,
  output logic          any_valid
);

  logic [PW-1:0] idx;

  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int k = 0; k < N; k++) begin
      idx = PW'((int'(ptr) + k) % N);
      if (!any_valid && valid[idx]) begin
        winner    = idx;
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/unpacked_rr_arbiter.sv
// Round-robin arbiter sharing one registered output channel among N lanes,
// with saturating per-lane grant counters.
//
//   state | meaning
//   EMPTY | output register holds no word; any winner may load
//   FULL  | output register holds a word; reload only when consumer takes it
module unpacked_rr_arbiter
  import unpacked_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 8,
  parameter int CW = 8,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          req_valid [N],
  input  logic [W-1:0]  req_data  [N],
  output logic          req_ready [N],
  output logic          out_valid,
  output logic [W-1:0]  out_data,
  output logic [PW-1:0] out_id,
  input  logic          out_ready,
  output logic [CW-1:0] grant_cnt [N]
);

  arb_state_t    state;
  logic [PW-1:0] ptr;
  logic [PW-1:0] winner;
  logic          any_valid;
  logic          can_load;
  logic          xfer;

  rr_pick #(.N(N), .PW(PW)) u_pick (
    .valid     (req_valid),
    .ptr       (ptr),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign can_load  = (state == EMPTY) | out_ready;
  // No acceptance while reset is held: the word would be dropped on the floor.
  assign xfer      = can_load & any_valid & ~reset;
  assign out_valid = (state == FULL);

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_ready[i] = xfer & (winner == PW'(i));
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= EMPTY;
      ptr      <= '0;
      out_data <= '0;
      out_id   <= '0;
    end else begin
      if (xfer) begin
        out_data <= req_data[winner];
        out_id   <= winner;
        ptr      <= PW'(next_idx(int'(winner), N));
        state    <= FULL;
      end else if (out_ready) begin
        state <= EMPTY;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) grant_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (xfer && (winner == PW'(i)) && (grant_cnt[i] != {CW{1'b1}}))
          grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
    end
  end

endmodule
